// File: rtl/layer3_pool_collector_pkg.sv
// Shared layer-3 definitions: collector state encoding, lane offset macro and
// default geometry of the pooled 5x5 feature map. Reused by the pool top and
// the downstream convolution stages.
`ifndef LANE
`define LANE(i) ((i) << bits_shift)
`endif

package layer3_pool_collector_pkg;

  // Default layer-3 geometry: 16 signed 16-bit channels per word, 5x5 positions.
  localparam int L3_BITS        = 16;
  localparam int L3_BITS_SHIFT  = 4;
  localparam int L3_CHANNEL_NUM = 16;
  localparam int L3_MAP_WORDS   = 25;
  localparam int L3_ADDR_W      = 5;

  typedef logic [1:0] col_state_t;

  // Collector FSM encoding, kept as plain constants for legacy consumers.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_FILL = 2'd1;
  localparam logic [1:0] ST_FULL = 2'd2;
  localparam logic [1:0] ST_READ = 2'd3;

endpackage

// File: rtl/pool_frame_ram.sv
// Frame buffer for one pooled feature map: one write port, registered read
// port. The read register only updates on rd_en so the output holds between
// replays; it is cleared by reset so the replay output starts at zero.
module pool_frame_ram #(
  parameter int width  = 256,
  parameter int depth  = 25,
  parameter int addr_w = 5
) (
  input  logic              clk_in,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [addr_w-1:0] wr_addr,
  input  logic [width-1:0]  wr_data,
  input  logic              rd_en,
  input  logic [addr_w-1:0] rd_addr,
  output logic [width-1:0]  rd_q
);

  logic [width-1:0] mem [depth];

  // Storage array: plain write, no reset, so it maps onto block RAM.
  always_ff @(posedge clk_in) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Registered read port; holds its value when not reading.
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      rd_q <= '0;
    end else if (rd_en) begin
      rd_q <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/layer3_pool_collector.sv
// Layer-3 pool collector: buffers one full pooled feature map from the pool
// stage (one packed word per ready_in strobe) and replays it in row-major
// order under rd_start, with rd_valid/rd_last framing.
// Optional build macro: LAYER3_COLLECT_RELU_EN clamps negative lanes to zero
// on write; without it lanes are stored bit-exact.
module layer3_pool_collector
  import layer3_pool_collector_pkg::*;
#(
  parameter int bits        = L3_BITS,
  parameter int bits_shift  = L3_BITS_SHIFT,
  parameter int channel_num = L3_CHANNEL_NUM,
  parameter int map_words   = L3_MAP_WORDS,
  parameter int addr_w      = L3_ADDR_W
) (
  input  logic                              clk_in,
  input  logic                              rst_n,
  input  logic                              start,
  input  logic [(channel_num<<bits_shift)-1:0] data_in,
  input  logic                              ready_in,
  input  logic                              rd_start,
  output logic [(channel_num<<bits_shift)-1:0] rd_data,
  output logic                              rd_valid,
  output logic                              rd_last,
  output logic                              frame_done,
  output logic                              overflow
);

  localparam int lane_pitch = 1 << bits_shift;
  localparam int word_w     = channel_num << bits_shift;
  localparam logic [addr_w-1:0] last_addr = addr_w'(map_words - 1);

  col_state_t        state_reg, state_next;
  logic [addr_w-1:0] wr_ptr_reg, wr_ptr_next;
  logic [addr_w-1:0] rd_ptr_reg, rd_ptr_next;
  logic              rd_valid_reg, rd_valid_next;
  logic              rd_last_reg, rd_last_next;
  logic              frame_done_reg, frame_done_next;
  logic              overflow_reg, overflow_next;

  logic              wr_en;
  logic [addr_w-1:0] wr_addr;
  logic              rd_en;
  logic [addr_w-1:0] rd_addr;
  logic [word_w-1:0] relu_mask;
  logic [word_w-1:0] wr_data;

  // Per-lane clamp mask: a set mask zeroes the whole value field of a lane.
  for (genvar gi = 0; gi < channel_num; gi++) begin : g_lane
    localparam int lo = `LANE(gi);
`ifdef LAYER3_COLLECT_RELU_EN
    assign relu_mask[lo +: bits] = {bits{data_in[lo + bits - 1]}};
`else
    assign relu_mask[lo +: bits] = '0;
`endif
    if (lane_pitch > bits) begin : g_pad
      assign relu_mask[lo + bits +: lane_pitch - bits] = '0;
    end
  end

  assign wr_data = data_in & ~relu_mask;

  // FSM and pointer next-state; start overrides everything else.
  always_comb begin
    state_next      = state_reg;
    wr_ptr_next     = wr_ptr_reg;
    rd_ptr_next     = rd_ptr_reg;
    rd_valid_next   = 1'b0;
    rd_last_next    = 1'b0;
    frame_done_next = frame_done_reg;
    overflow_next   = overflow_reg;
    wr_en           = 1'b0;
    wr_addr         = wr_ptr_reg;
    rd_en           = 1'b0;
    rd_addr         = rd_ptr_reg;

    if (start) begin
      state_next      = ST_FILL;
      wr_ptr_next     = '0;
      rd_ptr_next     = '0;
      frame_done_next = 1'b0;
      overflow_next   = 1'b0;
      if (ready_in) begin
        // A word arriving with start lands at index 0 of the new frame.
        wr_en   = 1'b1;
        wr_addr = '0;
        if (last_addr == '0) begin
          state_next      = ST_FULL;
          frame_done_next = 1'b1;
        end else begin
          wr_ptr_next = addr_w'(1);
        end
      end
    end else begin
      case (state_reg)
        ST_FILL: begin
          if (ready_in) begin
            wr_en = 1'b1;
            if (wr_ptr_reg == last_addr) begin
              state_next      = ST_FULL;
              frame_done_next = 1'b1;
            end else begin
              wr_ptr_next = wr_ptr_reg + addr_w'(1);
            end
          end
        end
        ST_FULL: begin
          if (ready_in) begin
            overflow_next = 1'b1;
          end
          if (rd_start) begin
            // First word is fetched on the rd_start edge so it appears next cycle.
            rd_en         = 1'b1;
            rd_addr       = '0;
            rd_valid_next = 1'b1;
            rd_last_next  = (last_addr == '0);
            rd_ptr_next   = (last_addr == '0) ? '0 : addr_w'(1);
            state_next    = ST_READ;
          end
        end
        ST_READ: begin
          if (ready_in) begin
            overflow_next = 1'b1;
          end
          if (rd_last_reg) begin
            // Last word is on the output this cycle; wind down the frame.
            state_next      = ST_IDLE;
            frame_done_next = 1'b0;
            rd_ptr_next     = '0;
            wr_ptr_next     = '0;
          end else begin
            rd_en         = 1'b1;
            rd_valid_next = 1'b1;
            rd_last_next  = (rd_ptr_reg == last_addr);
            if (rd_ptr_reg != last_addr) begin
              rd_ptr_next = rd_ptr_reg + addr_w'(1);
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  // State, pointer and flag registers with synchronous active-low reset.
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      state_reg      <= ST_IDLE;
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      rd_valid_reg   <= 1'b0;
      rd_last_reg    <= 1'b0;
      frame_done_reg <= 1'b0;
      overflow_reg   <= 1'b0;
    end else begin
      state_reg      <= state_next;
      wr_ptr_reg     <= wr_ptr_next;
      rd_ptr_reg     <= rd_ptr_next;
      rd_valid_reg   <= rd_valid_next;
      rd_last_reg    <= rd_last_next;
      frame_done_reg <= frame_done_next;
      overflow_reg   <= overflow_next;
    end
  end

  pool_frame_ram #(
    .width  (word_w),
    .depth  (map_words),
    .addr_w (addr_w)
  ) u_ram (
    .clk_in  (clk_in),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_q    (rd_data)
  );

  assign rd_valid   = rd_valid_reg;
  assign rd_last    = rd_last_reg;
  assign frame_done = frame_done_reg;
  assign overflow   = overflow_reg;

endmodule

// File: tb/tb_layer3_pool_collector.sv
// Bench for layer3_pool_collector: frame fill/replay, gapped writes, overflow,
// replay abort, start+ready corner, mid-fill reset and the optional ReLU clamp
// (expected lane values follow LAYER3_COLLECT_RELU_EN).
module tb_layer3_pool_collector;

  localparam int W = 256;
  localparam int N = 25;

`ifdef LAYER3_COLLECT_RELU_EN
  localparam bit relu_on = 1'b1;
`else
  localparam bit relu_on = 1'b0;
`endif

  logic         clk_in = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] data_in;
  logic         ready_in;
  logic         rd_start;
  logic [W-1:0] rd_data;
  logic         rd_valid;
  logic         rd_last;
  logic         frame_done;
  logic         overflow;

  layer3_pool_collector dut (
    .clk_in     (clk_in),
    .rst_n      (rst_n),
    .start      (start),
    .data_in    (data_in),
    .ready_in   (ready_in),
    .rd_start   (rd_start),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .rd_last    (rd_last),
    .frame_done (frame_done),
    .overflow   (overflow)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [15:0] a_in;
    logic [15:0] b_in;
    logic [15:0] a_exp;
    logic [15:0] b_exp;
  } vec_t;

  typedef struct {
    logic [W-1:0] data;
    logic         last;
  } exp_t;

  vec_t         tv [N];
  exp_t         exp_q [$];
  exp_t         mon_e;
  logic [W-1:0] frame_in  [N];
  logic [W-1:0] frame_exp [N];
  int           tests  = 0;
  int           failed = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Even lanes carry a, odd lanes carry b.
  function automatic logic [W-1:0] make_word(input logic [15:0] a, input logic [15:0] b);
    logic [W-1:0] w;
    w = '0;
    for (int i = 0; i < 16; i++) begin
      w[i*16 +: 16] = (i % 2 == 0) ? a : b;
    end
    return w;
  endfunction

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // Scoreboard: every valid replay word is compared against the queue head.
  always @(posedge clk_in) begin
    #1;
    if (rd_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        tests++;
        failed++;
        $display("FAIL unexpected_rd_valid: got rd_valid=1 expected 0");
      end else begin
        mon_e = exp_q.pop_front();
        check("rd_data", rd_data, mon_e.data);
        check("rd_last", {255'd0, rd_last}, {255'd0, mon_e.last});
      end
    end
  end

  task automatic load_ramp();
    for (int n = 0; n < N; n++) begin
      frame_in[n]  = make_word(16'(n + 1), 16'(n + 1));
      frame_exp[n] = frame_in[n];
    end
  endtask

  task automatic load_table();
    for (int n = 0; n < N; n++) begin
      frame_in[n]  = make_word(tv[n].a_in, tv[n].b_in);
      frame_exp[n] = make_word(tv[n].a_exp, tv[n].b_exp);
    end
  endtask

  task automatic start_pulse();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Write count words starting at index first, one write every gap cycles.
  task automatic write_range(input int first, input int count, input int gap);
    for (int n = first; n < first + count; n++) begin
      data_in  = frame_in[n];
      ready_in = 1'b1;
      tick();
      ready_in = 1'b0;
      if (n == N - 2) check("frame_done_early", {255'd0, frame_done}, 256'd0);
      if (n == N - 1) check("frame_done_rise", {255'd0, frame_done}, 256'd1);
      for (int j = 1; j < gap; j++) tick();
    end
  endtask

  task automatic replay_full();
    for (int i = 0; i < N; i++) begin
      exp_t e;
      e.data = frame_exp[i];
      e.last = (i == N - 1);
      exp_q.push_back(e);
    end
    rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
    for (int i = 0; i < N; i++) begin
      check("replay_valid", {255'd0, rd_valid}, 256'd1);
      check("replay_frame_done", {255'd0, frame_done}, 256'd1);
      if (i < N - 1) tick();
    end
    tick();
    check("post_valid", {255'd0, rd_valid}, 256'd0);
    check("post_last", {255'd0, rd_last}, 256'd0);
    check("post_frame_done", {255'd0, frame_done}, 256'd0);
    check("post_q_empty", 256'(exp_q.size()), 256'd0);
  endtask

  initial begin
    int vcnt;
    // Lane vectors for the clamp / bit-exact frame: {a_in, b_in, a_exp, b_exp}.
    tv[0] = '{16'h8001, 16'h7FFF, relu_on ? 16'h0000 : 16'h8001, 16'h7FFF};
    tv[1] = '{16'h7FFF, 16'h8001, 16'h7FFF, relu_on ? 16'h0000 : 16'h8001};
    tv[2] = '{16'hFFFF, 16'h0000, relu_on ? 16'h0000 : 16'hFFFF, 16'h0000};
    tv[3] = '{16'h8000, 16'h0001, relu_on ? 16'h0000 : 16'h8000, 16'h0001};
    tv[4] = '{16'h1234, 16'hABCD, 16'h1234, relu_on ? 16'h0000 : 16'hABCD};
    for (int n = 5; n < N; n++) begin
      tv[n].a_in  = 16'h0100 + 16'(n);
      tv[n].b_in  = 16'hF000 + 16'(n);
      tv[n].a_exp = tv[n].a_in;
      tv[n].b_exp = relu_on ? 16'h0000 : tv[n].b_in;
    end

    rst_n = 1'b0; start = 1'b0; ready_in = 1'b0; rd_start = 1'b0; data_in = '0;
    tick();
    tick();
    check("rst_rd_valid", {255'd0, rd_valid}, 256'd0);
    check("rst_rd_last", {255'd0, rd_last}, 256'd0);
    check("rst_frame_done", {255'd0, frame_done}, 256'd0);
    check("rst_overflow", {255'd0, overflow}, 256'd0);
    check("rst_rd_data", rd_data, 256'd0);
    rst_n = 1'b1;

    // ready_in in IDLE is ignored.
    data_in = make_word(16'h5555, 16'h5555);
    ready_in = 1'b1;
    tick();
    ready_in = 1'b0;
    check("idle_overflow", {255'd0, overflow}, 256'd0);
    check("idle_frame_done", {255'd0, frame_done}, 256'd0);

    // Contiguous ramp frame and replay.
    load_ramp();
    start_pulse();
    write_range(0, N, 1);
    replay_full();

    // Gapped writes, every third cycle.
    start_pulse();
    write_range(0, N, 3);
    replay_full();

    // Extra write while FULL sets sticky overflow; stored frame unchanged.
    start_pulse();
    write_range(0, N, 1);
    check("ovf_before", {255'd0, overflow}, 256'd0);
    data_in = make_word(16'hDEAD, 16'hDEAD);
    ready_in = 1'b1;
    tick();
    ready_in = 1'b0;
    check("ovf_set", {255'd0, overflow}, 256'd1);
    replay_full();
    check("ovf_sticky", {255'd0, overflow}, 256'd1);
    start_pulse();
    check("ovf_cleared", {255'd0, overflow}, 256'd0);

    // Abort a replay with start while word 10 is on the output.
    start_pulse();
    write_range(0, N, 1);
    for (int i = 0; i < 10; i++) begin
      exp_t e;
      e.data = frame_exp[i];
      e.last = 1'b0;
      exp_q.push_back(e);
    end
    rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("abort_valid", {255'd0, rd_valid}, 256'd0);
    check("abort_frame_done", {255'd0, frame_done}, 256'd0);
    check("abort_q_empty", 256'(exp_q.size()), 256'd0);
    // Already in FILL: a full frame needs no further start.
    load_table();
    write_range(0, N, 1);
    replay_full();

    // start and ready_in together: that word is index 0.
    start = 1'b1;
    ready_in = 1'b1;
    data_in = frame_in[0];
    tick();
    start = 1'b0;
    ready_in = 1'b0;
    check("sr_frame_done", {255'd0, frame_done}, 256'd0);
    write_range(1, N - 1, 1);
    replay_full();

    // Reset after 12 writes, then rd_start must be ignored.
    load_ramp();
    start_pulse();
    write_range(0, 12, 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("mid_rst_rd_valid", {255'd0, rd_valid}, 256'd0);
    check("mid_rst_rd_last", {255'd0, rd_last}, 256'd0);
    check("mid_rst_frame_done", {255'd0, frame_done}, 256'd0);
    check("mid_rst_overflow", {255'd0, overflow}, 256'd0);
    check("mid_rst_rd_data", rd_data, 256'd0);
    rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
    vcnt = (rd_valid === 1'b1) ? 1 : 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (rd_valid === 1'b1) vcnt++;
    end
    check("mid_rst_no_replay", 256'(vcnt), 256'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
